// File: rtl/in_port_pkg.sv
// rtl/in_port_pkg.sv - shared constants and helpers for the buffered input port
package in_port_pkg;

    localparam int IN_PORT_WIDTH_DEFAULT = 16;
    localparam int IN_PORT_DEPTH_DEFAULT = 4;

    // Control-word bit the decoder raises for IN-pop.
    localparam int IN_POP_BIT = 12;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/in_port_fifo.sv
// rtl/in_port_fifo.sv - register-array FIFO with separate occupancy count
module in_port_fifo
    import in_port_pkg::*;
#(
    parameter int WIDTH = IN_PORT_WIDTH_DEFAULT,
    parameter int DEPTH = IN_PORT_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Contents are not reset; the top masks rdata while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/in_port.sv
// rtl/in_port.sv - buffered input port; optional sticky underflow flag via IN_PORT_UNDERFLOW_EN
module in_port
    import in_port_pkg::*;
#(
    parameter int WIDTH = IN_PORT_WIDTH_DEFAULT,
    parameter int DEPTH = IN_PORT_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic                          i_ext_valid,
    input  logic [WIDTH-1:0]              i_ext_data,
    output logic                          o_ext_ready,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_empty,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic                          o_underflow
);

    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Ready depends only on registered occupancy, so a pop cannot make room in the same cycle.
    assign o_ext_ready = (o_count != FULL_COUNT);
    assign o_empty     = (o_count == '0);
    assign push        = i_ext_valid & o_ext_ready;
    assign pop         = clk_en & i_pop & ~o_empty;
    assign o_data      = o_empty ? '0 : head;

    in_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (i_ext_data),
        .rdata (head),
        .count (o_count)
    );

`ifdef IN_PORT_UNDERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_underflow <= 1'b0;
        end else if (clk_en & i_pop & o_empty) begin
            o_underflow <= 1'b1;
        end
    end
`else
    assign o_underflow = 1'b0;
`endif

endmodule
